vliw_bundle_ctrl: RTL and testbench

Registered control unit for the N-slot VLIW datapath. Each cycle it decodes one instruction bundle of SLOTS 16-bit slots into per-slot register and flag write enables, ALU controls, memory strobes and PC select. A small FSM sequences multi-cycle memory operations (stall, load writeback) and squashes the bundle after a taken jump or branch. Sits between fetch and the register file / ALU / data memory.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/vliw_bundle_ctrl_if.sv | 39 +++
 rtl/vliw_slot_dec.sv | 65 ++++++
 rtl/vliw_bundle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_vliw_bundle_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the VLIW bundle controller: slot encodings,
// ALU and PC-select codes, FSM states and the per-slot decode record.
package ctrl_pkg;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_ALU_R = 5'b01000;
   localparam logic [4:0] OP_ALU_I = 5'b00101;
   localparam logic [4:0] OP_LOAD  = 5'b01010;
   localparam logic [4:0] OP_STORE = 5'b01011;
   localparam logic [4:0] OP_JUMP  = 5'b11110;
   localparam logic [4:0] OP_BRN   = 5'b11011;

   localparam logic [2:0] SUB_ADD = 3'b100;
   localparam logic [2:0] SUB_SHF = 3'b011;
   localparam logic [2:0] SUB_LOG = 3'b010;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_IMM = 2'b01;
   localparam logic [1:0] ALU_LOG = 2'b10;
   localparam logic [1:0] ALU_SHF = 2'b11;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_LOAD_WB,
      ST_REDIRECT
   } state_t;

   typedef struct packed {
      logic       reg_write;
      logic       z_write;
      logic       n_write;
      logic       c_write;
      logic       v_write;
      logic [1:0] alu_op;
      logic       src_a;
      logic       src_b;
      logic       is_mem;
      logic       is_load;
      logic       is_ctrl;
      logic       is_jump;
      logic       bad;
   } slot_ctrl_t;

endpackage

// File: rtl/vliw_bundle_ctrl_if.sv
// Bundle/control bus between fetch + datapath (master) and the controller (slave).
interface vliw_bundle_ctrl_if #(
   parameter int SLOTS = 2,
   parameter int MSW   = (SLOTS > 1) ? $clog2(SLOTS) : 1
);
   logic [16*SLOTS-1:0] ir;
   logic                ir_valid;
   logic                n_flag;
   logic                mem_ready;
   logic [SLOTS-1:0]    reg_write;
   logic [SLOTS-1:0]    z_write;
   logic [SLOTS-1:0]    n_write;
   logic [SLOTS-1:0]    c_write;
   logic [SLOTS-1:0]    v_write;
   logic [2*SLOTS-1:0]  alu_op;
   logic [SLOTS-1:0]    alu_src_a;
   logic [SLOTS-1:0]    alu_src_b;
   logic                mem_read;
   logic                mem_write;
   logic [MSW-1:0]      mem_slot;
   logic                branch;
   logic [1:0]          pc_src;
   logic                stall;
   logic                illegal;

   modport master (
      output ir, ir_valid, n_flag, mem_ready,
      input  reg_write, z_write, n_write, c_write, v_write, alu_op,
             alu_src_a, alu_src_b, mem_read, mem_write, mem_slot,
             branch, pc_src, stall, illegal
   );

   modport slave (
      input  ir, ir_valid, n_flag, mem_ready,
      output reg_write, z_write, n_write, c_write, v_write, alu_op,
             alu_src_a, alu_src_b, mem_read, mem_write, mem_slot,
             branch, pc_src, stall, illegal
   );
endinterface

// File: rtl/vliw_slot_dec.sv
// Combinational decode of one 16-bit issue slot into its control record.
module vliw_slot_dec
   import ctrl_pkg::*;
#(
   parameter int SW = 16
) (
   input  logic [SW-1:0] slot,
   output slot_ctrl_t    ctrl
);
   logic [4:0] opcode;
   logic [2:0] subop;
   logic       unused_hi;

   assign opcode    = slot[4:0];
   assign subop     = slot[7:5];
   assign unused_hi = ^slot[SW-1:8];

   // Opcode/subop decode; anything unrecognised raises bad
   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_NOP: begin
         end
         OP_ALU_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.z_write   = 1'b1;
            ctrl.n_write   = 1'b1;
            ctrl.src_a     = 1'b1;
            case (subop)
               SUB_ADD: begin
                  ctrl.alu_op  = ALU_ADD;
                  ctrl.c_write = 1'b1;
                  ctrl.v_write = 1'b1;
               end
               SUB_SHF: begin
                  ctrl.alu_op  = ALU_SHF;
                  ctrl.c_write = 1'b1;
               end
               SUB_LOG: ctrl.alu_op = ALU_LOG;
               default: ctrl.bad = 1'b1;
            endcase
         end
         OP_ALU_I: begin
            ctrl.reg_write = 1'b1;
            ctrl.z_write   = 1'b1;
            ctrl.n_write   = 1'b1;
            ctrl.c_write   = 1'b1;
            ctrl.v_write   = 1'b1;
            ctrl.alu_op    = ALU_IMM;
            ctrl.src_b     = 1'b1;
         end
         OP_LOAD: begin
            ctrl.is_mem  = 1'b1;
            ctrl.is_load = 1'b1;
         end
         OP_STORE: ctrl.is_mem = 1'b1;
         OP_JUMP: begin
            ctrl.is_ctrl = 1'b1;
            ctrl.is_jump = 1'b1;
         end
         OP_BRN:  ctrl.is_ctrl = 1'b1;
         default: ctrl.bad = 1'b1;
      endcase
   end
endmodule

// File: rtl/vliw_bundle_ctrl.sv
// Registered VLIW bundle controller: per-slot decode, bundle conflict check,
// memory stall / load writeback / redirect-squash sequencing.
module vliw_bundle_ctrl
   import ctrl_pkg::*;
#(
   parameter int SLOTS = 2,
   parameter int SW    = 16,
   parameter int MSW   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   vliw_bundle_ctrl_if.slave bus
);
   slot_ctrl_t dec_p0 [SLOTS];

   for (genvar k = 0; k < SLOTS; k++) begin : g_slot
      vliw_slot_dec #(.SW(SW)) u_dec (
         .slot (bus.ir[SW*k +: SW]),
         .ctrl (dec_p0[k])
      );
   end

   logic           seen_mem, multi_mem, seen_ctrl, multi_ctrl;
   logic           any_bad, any_jump, mem_load, bundle_bad;
   logic [MSW-1:0] mem_idx;

   // Bundle-level classification and structural conflict check
   always_comb begin
      seen_mem   = 1'b0;
      multi_mem  = 1'b0;
      seen_ctrl  = 1'b0;
      multi_ctrl = 1'b0;
      any_bad    = 1'b0;
      any_jump   = 1'b0;
      mem_load   = 1'b0;
      mem_idx    = '0;
      for (int k = 0; k < SLOTS; k++) begin
         multi_mem  = multi_mem | (seen_mem & dec_p0[k].is_mem);
         seen_mem   = seen_mem | dec_p0[k].is_mem;
         multi_ctrl = multi_ctrl | (seen_ctrl & dec_p0[k].is_ctrl);
         seen_ctrl  = seen_ctrl | dec_p0[k].is_ctrl;
         any_bad    = any_bad | dec_p0[k].bad;
         any_jump   = any_jump | dec_p0[k].is_jump;
         if (dec_p0[k].is_mem) begin
            mem_idx  = MSW'(k);
            mem_load = dec_p0[k].is_load;
         end
      end
      bundle_bad = any_bad | multi_mem | multi_ctrl | (seen_mem & seen_ctrl);
   end

   state_t             state, state_nxt;
   logic [SLOTS-1:0]   reg_write_p0, z_write_p0, n_write_p0, c_write_p0, v_write_p0;
   logic [SLOTS-1:0]   src_a_p0, src_b_p0;
   logic [2*SLOTS-1:0] alu_op_p0;
   logic               mem_read_p0, mem_write_p0, branch_p0, illegal_p0;
   logic [MSW-1:0]     mem_slot_p0;
   logic [1:0]         pc_src_p0;

   // Next state and the control values to register for the next cycle
   always_comb begin
      state_nxt    = state;
      reg_write_p0 = '0;
      z_write_p0   = '0;
      n_write_p0   = '0;
      c_write_p0   = '0;
      v_write_p0   = '0;
      src_a_p0     = '0;
      src_b_p0     = '0;
      alu_op_p0    = '0;
      mem_read_p0  = 1'b0;
      mem_write_p0 = 1'b0;
      mem_slot_p0  = '0;
      branch_p0    = 1'b0;
      pc_src_p0    = PC_SEQ;
      illegal_p0   = 1'b0;
      case (state)
         ST_RUN: begin
            if (bus.ir_valid) begin
               if (bundle_bad) begin
                  illegal_p0 = 1'b1;
               end else begin
                  for (int k = 0; k < SLOTS; k++) begin
                     reg_write_p0[k]      = dec_p0[k].reg_write;
                     z_write_p0[k]        = dec_p0[k].z_write;
                     n_write_p0[k]        = dec_p0[k].n_write;
                     c_write_p0[k]        = dec_p0[k].c_write;
                     v_write_p0[k]        = dec_p0[k].v_write;
                     src_a_p0[k]          = dec_p0[k].src_a;
                     src_b_p0[k]          = dec_p0[k].src_b;
                     alu_op_p0[2*k +: 2]  = dec_p0[k].alu_op;
                  end
                  if (seen_mem) begin
                     mem_read_p0  = mem_load;
                     mem_write_p0 = ~mem_load;
                     mem_slot_p0  = mem_idx;
                     state_nxt    = ST_MEM_WAIT;
                  end
                  if (any_jump) begin
                     pc_src_p0 = PC_JMP;
                     state_nxt = ST_REDIRECT;
                  end else if (seen_ctrl) begin
                     branch_p0 = 1'b1;
                     if (bus.n_flag) begin
                        pc_src_p0 = PC_BR;
                        state_nxt = ST_REDIRECT;
                     end
                  end
               end
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready) begin
               // Access completes: loads get one writeback cycle on their slot
               if (bus.mem_read) begin
                  state_nxt = ST_LOAD_WB;
                  for (int k = 0; k < SLOTS; k++) begin
                     if (MSW'(k) == bus.mem_slot) begin
                        reg_write_p0[k] = 1'b1;
                        z_write_p0[k]   = 1'b1;
                        n_write_p0[k]   = 1'b1;
                     end
                  end
               end else begin
                  state_nxt = ST_RUN;
               end
            end else begin
               mem_read_p0  = bus.mem_read;
               mem_write_p0 = bus.mem_write;
               mem_slot_p0  = bus.mem_slot;
            end
         end
         ST_LOAD_WB:  state_nxt = ST_RUN;
         ST_REDIRECT: state_nxt = ST_RUN;
         default:     state_nxt = ST_RUN;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // Registered control outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.reg_write <= '0;
         bus.z_write   <= '0;
         bus.n_write   <= '0;
         bus.c_write   <= '0;
         bus.v_write   <= '0;
         bus.alu_op    <= '0;
         bus.alu_src_a <= '0;
         bus.alu_src_b <= '0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.mem_slot  <= '0;
         bus.branch    <= 1'b0;
         bus.pc_src    <= PC_SEQ;
         bus.illegal   <= 1'b0;
      end else begin
         bus.reg_write <= reg_write_p0;
         bus.z_write   <= z_write_p0;
         bus.n_write   <= n_write_p0;
         bus.c_write   <= c_write_p0;
         bus.v_write   <= v_write_p0;
         bus.alu_op    <= alu_op_p0;
         bus.alu_src_a <= src_a_p0;
         bus.alu_src_b <= src_b_p0;
         bus.mem_read  <= mem_read_p0;
         bus.mem_write <= mem_write_p0;
         bus.mem_slot  <= mem_slot_p0;
         bus.branch    <= branch_p0;
         bus.pc_src    <= pc_src_p0;
         bus.illegal   <= illegal_p0;
      end
   end

   // Fetch holds the bundle while a memory access or its writeback is in flight
   assign bus.stall = (state == ST_MEM_WAIT) || (state == ST_LOAD_WB);

endmodule

// File: tb/tb_vliw_bundle_ctrl.sv
// Scoreboard bench for vliw_bundle_ctrl: a 2-slot and a 4-slot instance,
// directed bundles with hand-derived expected controls.
module tb_vliw_bundle_ctrl;

   typedef struct packed {
      logic [3:0] rw, z, n, c, v;
      logic [7:0] alu;
      logic [3:0] sa, sb;
      logic       mr, mw;
      logic [1:0] ms;
      logic       br;
      logic [1:0] pc;
      logic       st, il;
   } out_t;

   typedef struct {
      int    cyc;
      string name;
      out_t  e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vliw_bundle_ctrl_if #(.SLOTS(2)) bus_a ();
   vliw_bundle_ctrl_if #(.SLOTS(4)) bus_b ();

   vliw_bundle_ctrl #(.SLOTS(2)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
   vliw_bundle_ctrl #(.SLOTS(4)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

   task automatic step_a(input logic r, input logic [31:0] ir, input logic vld,
                         input logic nf, input logic mrdy, input string nm, input out_t e);
      exp_t x;
      rst_a = r;
      bus_a.ir = ir;
      bus_a.ir_valid = vld;
      bus_a.n_flag = nf;
      bus_a.mem_ready = mrdy;
      x.cyc = cyc + 1;
      x.name = nm;
      x.e = e;
      qa.push_back(x);
      @(posedge clk);
      #2;
   endtask

   task automatic step_b(input logic r, input logic [63:0] ir, input logic vld,
                         input logic nf, input logic mrdy, input string nm, input out_t e);
      exp_t x;
      rst_b = r;
      bus_b.ir = ir;
      bus_b.ir_valid = vld;
      bus_b.n_flag = nf;
      bus_b.mem_ready = mrdy;
      x.cyc = cyc + 1;
      x.name = nm;
      x.e = e;
      qb.push_back(x);
      @(posedge clk);
      #2;
   endtask

   // Monitor: every cycle, compare the outputs against whatever was predicted for it
   initial begin
      out_t act_a, act_b;
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         act_a = '0;
         act_a.rw = 4'(bus_a.reg_write);
         act_a.z = 4'(bus_a.z_write);
         act_a.n = 4'(bus_a.n_write);
         act_a.c = 4'(bus_a.c_write);
         act_a.v = 4'(bus_a.v_write);
         act_a.alu = 8'(bus_a.alu_op);
         act_a.sa = 4'(bus_a.alu_src_a);
         act_a.sb = 4'(bus_a.alu_src_b);
         act_a.mr = bus_a.mem_read;
         act_a.mw = bus_a.mem_write;
         act_a.ms = 2'(bus_a.mem_slot);
         act_a.br = bus_a.branch;
         act_a.pc = bus_a.pc_src;
         act_a.st = bus_a.stall;
         act_a.il = bus_a.illegal;
         act_b.rw = bus_b.reg_write;
         act_b.z = bus_b.z_write;
         act_b.n = bus_b.n_write;
         act_b.c = bus_b.c_write;
         act_b.v = bus_b.v_write;
         act_b.alu = bus_b.alu_op;
         act_b.sa = bus_b.alu_src_a;
         act_b.sb = bus_b.alu_src_b;
         act_b.mr = bus_b.mem_read;
         act_b.mw = bus_b.mem_write;
         act_b.ms = bus_b.mem_slot;
         act_b.br = bus_b.branch;
         act_b.pc = bus_b.pc_src;
         act_b.st = bus_b.stall;
         act_b.il = bus_b.illegal;
         while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            x = qa.pop_front();
            checks++;
            if (x.cyc != cyc || act_a !== x.e) begin
               errors++;
               $display("FAIL a.%s (cycle %0d): got %h expected %h", x.name, x.cyc, act_a, x.e);
            end
         end
         while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            x = qb.pop_front();
            checks++;
            if (x.cyc != cyc || act_b !== x.e) begin
               errors++;
               $display("FAIL b.%s (cycle %0d): got %h expected %h", x.name, x.cyc, act_b, x.e);
            end
         end
      end
   end

   // Stimulus
   initial begin
      out_t e, add_o;
      rst_a = 1'b0;
      rst_b = 1'b0;
      bus_a.ir = '0; bus_a.ir_valid = 1'b0; bus_a.n_flag = 1'b0; bus_a.mem_ready = 1'b0;
      bus_b.ir = '0; bus_b.ir_valid = 1'b0; bus_b.n_flag = 1'b0; bus_b.mem_ready = 1'b0;
      @(posedge clk);
      #2;

      // ALU_R add in slot 0: z/n/c/v write, alu_op 00, src_a 1
      add_o = '0;
      add_o.rw = 4'b0001; add_o.z = 4'b0001; add_o.n = 4'b0001;
      add_o.c = 4'b0001; add_o.v = 4'b0001; add_o.sa = 4'b0001;

      // Reset held, then released
      e = '0;
      step_a(1'b0, 32'h0000_0088, 1'b1, 1'b0, 1'b0, "reset_0", e);
      step_a(1'b0, 32'h0000_0088, 1'b1, 1'b0, 1'b0, "reset_1", e);
      step_a(1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b0, "alu_r_add", add_o);
      e = '0;
      step_a(1'b1, 32'h0000_0088, 1'b0, 1'b0, 1'b0, "valid_low", e);

      // ALU_I slot 0 + LOAD slot 1, mem_ready low for 3 cycles
      e = '0;
      e.rw = 4'b0001; e.z = 4'b0001; e.n = 4'b0001; e.c = 4'b0001; e.v = 4'b0001;
      e.alu = 8'h01; e.sb = 4'b0001; e.mr = 1'b1; e.ms = 2'd1; e.st = 1'b1;
      step_a(1'b1, 32'h000A_0005, 1'b1, 1'b0, 1'b0, "load_issue", e);
      e = '0; e.mr = 1'b1; e.ms = 2'd1; e.st = 1'b1;
      step_a(1'b1, 32'h000A_0005, 1'b1, 1'b0, 1'b0, "load_wait1", e);
      step_a(1'b1, 32'h000A_0005, 1'b1, 1'b0, 1'b0, "load_wait2", e);
      step_a(1'b1, 32'h000A_0005, 1'b1, 1'b0, 1'b0, "load_wait3", e);
      e = '0; e.rw = 4'b0010; e.z = 4'b0010; e.n = 4'b0010; e.st = 1'b1;
      step_a(1'b1, 32'h000A_0005, 1'b1, 1'b0, 1'b1, "load_wb", e);
      e = '0;
      step_a(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "load_done", e);

      // BRN taken: next bundle squashed
      e = '0; e.br = 1'b1; e.pc = 2'b01;
      step_a(1'b1, 32'h001B_0000, 1'b1, 1'b1, 1'b0, "brn_taken", e);
      e = '0;
      step_a(1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b0, "brn_squash", e);
      step_a(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "brn_after", e);
      // BRN not taken: next bundle executes
      e = '0; e.br = 1'b1;
      step_a(1'b1, 32'h001B_0000, 1'b1, 1'b0, 1'b0, "brn_not_taken", e);
      step_a(1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b0, "brn_fallthru", add_o);

      // JUMP: pc_src 10 once, then squash
      e = '0; e.pc = 2'b10;
      step_a(1'b1, 32'h001E_0000, 1'b1, 1'b0, 1'b0, "jump", e);
      e = '0;
      step_a(1'b1, 32'h0000_0088, 1'b1, 1'b0, 1'b0, "jump_squash", e);
      step_a(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "jump_after", e);

      // Shift in slot 1, logic op in slot 0
      e = '0;
      e.rw = 4'b0011; e.z = 4'b0011; e.n = 4'b0011; e.c = 4'b0010;
      e.alu = 8'h0E; e.sa = 4'b0011;
      step_a(1'b1, 32'h0068_0048, 1'b1, 1'b0, 1'b0, "shf_log", e);

      // Illegal bundles, each followed by an idle cycle
      e = '0; e.il = 1'b1;
      step_a(1'b1, 32'h000A_000A, 1'b1, 1'b0, 1'b1, "ill_two_mem", e);
      e = '0;
      step_a(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "ill_pulse1", e);
      e = '0; e.il = 1'b1;
      step_a(1'b1, 32'h001E_000B, 1'b1, 1'b0, 1'b0, "ill_jump_store", e);
      e = '0;
      step_a(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "ill_pulse2", e);
      e = '0; e.il = 1'b1;
      step_a(1'b1, 32'h0000_001F, 1'b1, 1'b0, 1'b0, "ill_opcode", e);
      step_a(1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b0, "ill_subop", e);
      step_a(1'b1, 32'h001B_001E, 1'b1, 1'b1, 1'b0, "ill_two_ctrl", e);
      e = '0;
      step_a(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "ill_pulse3", e);

      // 4-slot instance: STORE slot 3 with mem_ready already high
      e = '0;
      step_b(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, "b_reset", e);
      e = '0; e.mw = 1'b1; e.ms = 2'd3; e.st = 1'b1;
      step_b(1'b1, 64'h000B_0000_0000_0000, 1'b1, 1'b0, 1'b1, "b_store", e);
      e = '0;
      step_b(1'b1, 64'h000B_0000_0000_0000, 1'b1, 1'b0, 1'b1, "b_store_done", e);
      step_b(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, "b_idle", e);
      // LOAD slot 2, reset during the wait
      e = '0; e.mr = 1'b1; e.ms = 2'd2; e.st = 1'b1;
      step_b(1'b1, 64'h0000_000A_0000_0000, 1'b1, 1'b0, 1'b0, "b_load", e);
      step_b(1'b1, 64'h0000_000A_0000_0000, 1'b1, 1'b0, 1'b0, "b_load_wait", e);
      e = '0;
      step_b(1'b0, 64'h0000_000A_0000_0000, 1'b1, 1'b0, 1'b0, "b_reset_wait", e);
      e = '0;
      e.rw = 4'b0001; e.z = 4'b0001; e.n = 4'b0001; e.c = 4'b0001; e.v = 4'b0001;
      e.alu = 8'h01; e.sb = 4'b0001;
      step_b(1'b1, 64'h0000_0000_0000_0005, 1'b1, 1'b0, 1'b0, "b_after_reset", e);
      e = '0;
      step_b(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, "b_idle2", e);

      repeat (3) @(posedge clk);
      #2;
      if (qa.size() + qb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", qa.size() + qb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
